// File: rtl/msrv32_pc_fetch_unit.sv
// Fetch stage: keeps one instruction-memory request outstanding at a time and
// presents each fetched word with its PC until downstream accepts it.
module msrv32_pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             branch_taken_in,
  input  logic [WIDTH-1:0] target_in,
  input  logic             trap_taken_in,
  input  logic [WIDTH-1:0] trap_address_in,
  input  logic             mret_in,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             stall_in,
  output logic             i_req_out,
  output logic [WIDTH-1:0] i_addr_out,
  input  logic             i_ack_in,
  input  logic [WIDTH-1:0] i_rdata_in,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_4_out,
  output logic             instr_valid_out,
  output logic             misaligned_instr_out
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, MISALIGN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic             misaligned;
  } next_pc_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] trap_pc;
  logic [WIDTH-1:0] pc_plus_4;
  next_pc_t         nxt;

  // Low address bits are discarded by the alignment rules below.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{target_in[0], trap_address_in[1:0], epc_in[1:0]};

  assign trap_pc   = {trap_address_in[WIDTH-1:2], 2'b00};
  assign pc_plus_4 = pc_q + WIDTH'(4);

  // Redirect priority: trap > mret > taken branch > sequential.
  always_comb begin
    nxt.pc         = pc_plus_4;
    nxt.misaligned = 1'b0;
    if (trap_taken_in) begin
      nxt.pc = trap_pc;
    end else if (mret_in) begin
      nxt.pc = {epc_in[WIDTH-1:2], 2'b00};
    end else if (branch_taken_in) begin
      nxt.pc         = {target_in[WIDTH-1:1], 1'b0};
      nxt.misaligned = target_in[1];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (trap_taken_in) begin
          // Abandon the outstanding request; a same-cycle ack is dropped.
          fetch_pc_d = trap_pc;
          state_d    = IDLE;
        end else if (i_ack_in) begin
          instr_d = i_rdata_in;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        // A trap redirects even while downstream is stalled.
        if (!stall_in || trap_taken_in) begin
          fetch_pc_d = nxt.pc;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
          state_d    = nxt.misaligned ? MISALIGN : FETCH;
        end
      end
      MISALIGN: begin
        if (trap_taken_in) begin
          fetch_pc_d = trap_pc;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDRESS;
      pc_q       <= BOOT_ADDRESS;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign i_req_out            = (state_q == FETCH);
  assign i_addr_out           = fetch_pc_q;
  assign instr_out            = instr_q;
  assign pc_out               = pc_q;
  assign pc_plus_4_out        = pc_plus_4;
  assign instr_valid_out      = valid_q;
  assign misaligned_instr_out = (state_q == MISALIGN);

endmodule
